div32x16_seq: RTL and testbench

- Sequential restoring divider; the inverse of the existing 16x16 multiplier in the DBNS arithmetic datapath.
- Takes a DW-bit dividend and a VW-bit divisor. Produces a DW-bit quotient and a VW-bit remainder.
- Retires one quotient bit per clock.
- Start/done handshake so a controller can chain it after the multiplier, e.g. for multiply-then-divide checks.

---
 rtl/div32x16_seq.sv | 134 +++++++++++++
 tb/tb_div32x16_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div32x16_seq.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Define DIV32X16_SIGNED_EN for two's complement operands with truncating division.
module div32x16_seq #(
  parameter int DW = 32,
  parameter int VW = 16,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] REGA,
  input  logic [VW-1:0] REGB,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] REGQ,
  output logic [VW-1:0] REGR,
  output logic          dbz
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_ZDIV = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [VW:0]   p;
  logic [DW-1:0] q;
  logic [VW-1:0] dvs;

  logic [DW-1:0] a_in;
  logic [VW-1:0] b_in;
  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;
  logic          ge;
  logic [VW:0]   p_next;
  logic [DW-1:0] q_next;
  logic [DW-1:0] q_res;
  logic [VW-1:0] r_res;

`ifdef DIV32X16_SIGNED_EN
  logic sign_q;
  logic sign_r;

  // Magnitudes go into the unsigned core; signs are reapplied on the done edge.
  always_comb begin
    a_in  = REGA[DW-1] ? -REGA : REGA;
    b_in  = REGB[VW-1] ? -REGB : REGB;
    q_res = sign_q ? -q_next : q_next;
    r_res = sign_r ? -p_next[VW-1:0] : p_next[VW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (state == S_IDLE && start) begin
      sign_q <= REGA[DW-1] ^ REGB[VW-1];
      sign_r <= REGA[DW-1];
    end
  end
`else
  always_comb begin
    a_in  = REGA;
    b_in  = REGB;
    q_res = q_next;
    r_res = p_next[VW-1:0];
  end
`endif

  // One restoring step; the extra top bit of diff is the borrow that decides the quotient bit.
  always_comb begin
    shifted = {p, q[DW-1]};
    diff    = shifted - {2'b00, dvs};
    ge      = ~diff[VW+1];
    p_next  = ge ? diff[VW:0] : shifted[VW:0];
    q_next  = {q[DW-2:0], ge};
  end

  assign busy = (state == S_CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      p     <= '0;
      q     <= '0;
      dvs   <= '0;
      done  <= 1'b0;
      REGQ  <= '0;
      REGR  <= '0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dvs <= b_in;
            p   <= '0;
            cnt <= CW'(DW);
            // Divide-by-zero keeps the raw dividend so the remainder reports its low bits.
            if (REGB == '0) begin
              q     <= REGA;
              state <= S_ZDIV;
            end else begin
              q     <= a_in;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            REGQ  <= q_res;
            REGR  <= r_res;
            dbz   <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ZDIV: begin
          REGQ  <= '1;
          REGR  <= q[VW-1:0];
          dbz   <= 1'b1;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32x16_seq.sv
// Scoreboard bench for div32x16_seq: directed vectors push expected results, a monitor checks on done.
// Signed vectors run when DIV32X16_SIGNED_EN is defined.
module tb_div32x16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] REGA;
  logic [15:0] REGB;
  logic        busy;
  logic        done;
  logic [31:0] REGQ;
  logic [15:0] REGR;
  logic        dbz;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    int          acc;
    int          lat;
    int          bsy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   busy_run = 0;
  int   checks = 0;
  int   errors = 0;

  div32x16_seq #(.DW(32), .VW(16), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .REGA(REGA), .REGB(REGB),
    .busy(busy), .done(done), .REGQ(REGQ), .REGR(REGR), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Issue a one-cycle start; optionally record the expected result for the monitor.
  task automatic applyStimulus(input logic [31:0] a, input logic [15:0] b, input logic [31:0] eq,
                               input logic [15:0] er, input logic ez, input bit push);
    exp_t e;
    @(negedge clk);
    REGA  = a;
    REGB  = b;
    start = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.z = ez;
      e.acc = cyc + 1;
      e.lat = ez ? 1 : 32;
      e.bsy = ez ? 0 : 32;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: counts busy cycles and compares each done pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_run = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: REGQ=0x%08h with no request outstanding", REGQ);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", REGQ, e.q);
        checkOutput("remainder", {16'h0, REGR}, {16'h0, e.r});
        checkOutput("dbz", {31'h0, dbz}, {31'h0, e.z});
        checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
        checkOutput("busy_cycles", 32'(busy_run), 32'(e.bsy));
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    REGA  = '0;
    REGB  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_regq", REGQ, 32'h0);
    checkOutput("reset_regr", {16'h0, REGR}, 32'h0);
    checkOutput("reset_dbz", {31'h0, dbz}, 32'h0);
    rst = 1'b1;

    $display("[TB] basic and boundary vectors");
    applyStimulus(32'd100000, 16'd7, 32'd14285, 16'd5, 1'b0, 1'b1);
    drain();
`ifdef DIV32X16_SIGNED_EN
    applyStimulus(32'hFFFFFFFF, 16'hFFFF, 32'h00000001, 16'h0000, 1'b0, 1'b1);
`else
    applyStimulus(32'hFFFFFFFF, 16'hFFFF, 32'h00010001, 16'h0000, 1'b0, 1'b1);
`endif
    drain();
    applyStimulus(32'd5, 16'd9, 32'd0, 16'd5, 1'b0, 1'b1);
    drain();

    $display("[TB] divide by zero");
    applyStimulus(32'h12345678, 16'h0000, 32'hFFFFFFFF, 16'h5678, 1'b1, 1'b1);
    drain();
    applyStimulus(32'd10, 16'd3, 32'd3, 16'd1, 1'b0, 1'b1);
    drain();

    $display("[TB] start ignored while busy");
    applyStimulus(32'd100000, 16'd7, 32'd14285, 16'd5, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    applyStimulus(32'd1, 16'd1, 32'd1, 16'd0, 1'b0, 1'b0);
    drain();
    repeat (40) @(negedge clk);

    $display("[TB] start held high");
    @(negedge clk);
    REGA  = 32'd1000;
    REGB  = 16'd3;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.q = 32'd333; e.r = 16'd1; e.z = 1'b0;
      e.acc = cyc + 1; e.lat = 32; e.bsy = 32;
      sb.push_back(e);
      if (k < 2) repeat (33) @(negedge clk);
    end
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    $display("[TB] reset mid-operation");
    applyStimulus(32'd100000, 16'd7, 32'd0, 16'd0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    checkOutput("abort_done", {31'h0, done}, 32'h0);
    checkOutput("abort_regq", REGQ, 32'h0);
    checkOutput("abort_regr", {16'h0, REGR}, 32'h0);
    checkOutput("abort_dbz", {31'h0, dbz}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(32'd100, 16'd10, 32'd10, 16'd0, 1'b0, 1'b1);
    drain();

`ifdef DIV32X16_SIGNED_EN
    $display("[TB] signed vectors");
    applyStimulus(32'hFFFFFF9C, 16'd7, 32'hFFFFFFF2, 16'hFFFE, 1'b0, 1'b1);
    drain();
    applyStimulus(32'h80000000, 16'hFFFF, 32'h80000000, 16'h0000, 1'b0, 1'b1);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
